// File: rtl/digit_stroker.sv
// digit_stroker: walks a digit's stroke table and rasterises pen-down segments into a pixel stream
module digit_stroker #(
  parameter int MAX_IDX = 31,
  parameter int ERR_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit,
  input  logic [7:0] org_x,
  input  logic [7:0] org_y,
  output logic [4:0] idx,
  output logic [3:0] select,
  input  logic [7:0] seg_start_x,
  input  logic [7:0] seg_start_y,
  input  logic [7:0] seg_end_x,
  input  logic [7:0] seg_end_y,
  input  logic       seg_pen,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STEP, NEXT, DONE} state_t;
  localparam logic [4:0] LAST = 5'(MAX_IDX);
  state_t state_q;
  logic [4:0] idx_q;
  logic [3:0] sel_q;
  logic [7:0] org_x_q, org_y_q, sx_q, sy_q, ex_q, ey_q, cx_q, cy_q, pix_x_q, pix_y_q;
  logic valid_q, busy_q, done_q, stx_neg_q, sty_neg_q;
  logic signed [ERR_W-1:0] dx_q, dy_q, err_q, e2, err_d, adx, ady;
  logic [7:0] dxa, dya, cx_d, cy_d;
  logic step_x, step_y, at_end, term;
  assign idx       = idx_q;
  assign select    = sel_q;
  assign pix_valid = valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Segment deltas for SETUP and the next Bresenham position for STEP
  always_comb begin
    dxa    = ex_q >= sx_q ? ex_q - sx_q : sx_q - ex_q;
    dya    = ey_q >= sy_q ? ey_q - sy_q : sy_q - ey_q;
    adx    = ERR_W'(dxa);
    ady    = ERR_W'(dya);
    e2     = err_q <<< 1;
    step_x = e2 >= dy_q;
    step_y = e2 <= dx_q;
    err_d  = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    cx_d   = step_x ? (stx_neg_q ? cx_q - 8'd1 : cx_q + 8'd1) : cx_q;
    cy_d   = step_y ? (sty_neg_q ? cy_q - 8'd1 : cy_q + 8'd1) : cy_q;
    at_end = cx_q == ex_q && cy_q == ey_q;
    term   = seg_start_x == 8'd0 && seg_start_y == 8'd0 && seg_end_x == 8'd0 && seg_end_y == 8'd0 && !seg_pen;
  end
  // Stroke sequencer and rasteriser with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= '0;
      org_x_q   <= '0;
      org_y_q   <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stx_neg_q <= 1'b0;
      sty_neg_q <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sel_q   <= digit;
          org_x_q <= org_x;
          org_y_q <= org_y;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          sx_q    <= seg_start_x;
          sy_q    <= seg_start_y;
          ex_q    <= seg_end_x;
          ey_q    <= seg_end_y;
          done_q  <= term;
          state_q <= term ? DONE : seg_pen ? SETUP : NEXT;
        end
        SETUP: begin
          dx_q      <= adx;
          dy_q      <= -ady;
          err_q     <= adx - ady;
          stx_neg_q <= ex_q < sx_q;
          sty_neg_q <= ey_q < sy_q;
          cx_q      <= sx_q;
          cy_q      <= sy_q;
          pix_x_q   <= org_x_q + sx_q;
          pix_y_q   <= org_y_q + sy_q;
          valid_q   <= 1'b1;
          state_q   <= STEP;
        end
        STEP: if (pix_ready) begin
          if (at_end) begin
            valid_q <= 1'b0;
            state_q <= NEXT;
          end else begin
            err_q   <= err_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pix_x_q <= org_x_q + cx_d;
            pix_y_q <= org_y_q + cy_d;
          end
        end
        NEXT: begin
          done_q  <= idx_q == LAST;
          idx_q   <= idx_q == LAST ? idx_q : idx_q + 5'd1;
          state_q <= idx_q == LAST ? DONE : FETCH;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_stroker.sv
// tb_digit_stroker: stub stroke table plus a Bresenham reference model checking the pixel stream
module tb_digit_stroker;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] digit = 0;
  logic [7:0] org_x = 0, org_y = 0;
  logic [4:0] idx;
  logic [3:0] select;
  logic [7:0] seg_start_x, seg_start_y, seg_end_x, seg_end_y;
  logic seg_pen, pix_valid, busy, done;
  logic pix_ready = 0;
  logic [7:0] pix_x, pix_y;
  int passed = 0, total = 0;
  logic [7:0] t_sx[32], t_sy[32], t_ex[32], t_ey[32];
  logic t_pen[32];
  logic [3:0] t_dig = 0;
  logic [15:0] got[$], exp_q[$];
  int got_cyc[$];
  int cyc = 0, done_cnt = 0;
  logic [4:0] max_idx = 0;

  always #5 clk = ~clk;

  digit_stroker dut (
    .clk(clk), .rst(rst), .start(start), .digit(digit), .org_x(org_x), .org_y(org_y),
    .idx(idx), .select(select), .seg_start_x(seg_start_x), .seg_start_y(seg_start_y),
    .seg_end_x(seg_end_x), .seg_end_y(seg_end_y), .seg_pen(seg_pen),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done)
  );

  assign seg_start_x = select == t_dig ? t_sx[idx] : 8'd0;
  assign seg_start_y = select == t_dig ? t_sy[idx] : 8'd0;
  assign seg_end_x   = select == t_dig ? t_ex[idx] : 8'd0;
  assign seg_end_y   = select == t_dig ? t_ey[idx] : 8'd0;
  assign seg_pen     = select == t_dig ? t_pen[idx] : 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (pix_valid && pix_ready) begin
      got.push_back({pix_x, pix_y});
      got_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (busy && idx > max_idx) max_idx = idx;
  end

  function automatic int first_diff();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) return i;
    return got.size() == exp_q.size() ? -1 : (got.size() < exp_q.size() ? got.size() : exp_q.size());
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      t_sx[i] = 0; t_sy[i] = 0; t_ex[i] = 0; t_ey[i] = 0; t_pen[i] = 0;
    end
  endtask

  task automatic set_seg(input int i, input logic [7:0] a, b, c, d, input logic p);
    t_sx[i] = a; t_sy[i] = b; t_ex[i] = c; t_ey[i] = d; t_pen[i] = p;
  endtask

  // Reference: textbook integer Bresenham over the table, stopping at the first terminator
  task automatic model(input logic [7:0] ox, oy);
    int x, y, x1, y1, dx, dy, sx, sy, err, e2;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (t_sx[i] == 0 && t_sy[i] == 0 && t_ex[i] == 0 && t_ey[i] == 0 && !t_pen[i]) break;
      if (!t_pen[i]) continue;
      x = t_sx[i]; y = t_sy[i]; x1 = t_ex[i]; y1 = t_ey[i];
      dx = x1 > x ? x1 - x : x - x1;
      dy = -(y1 > y ? y1 - y : y - y1);
      sx = x1 >= x ? 1 : -1;
      sy = y1 >= y ? 1 : -1;
      err = dx + dy;
      for (int k = 0; k < 600; k++) begin
        exp_q.push_back({8'(int'(ox) + x), 8'(int'(oy) + y)});
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
  endtask

  task automatic start_digit(input logic [3:0] d, input logic [7:0] ox, oy);
    got.delete(); got_cyc.delete(); done_cnt = 0; max_idx = 0;
    @(posedge clk); #1;
    digit = d; org_x = ox; org_y = oy; start = 1;
    @(posedge clk); #1;
    start = 0; digit = ~d; org_x = 8'($urandom); org_y = 8'($urandom);
  endtask

  task automatic wait_idle(input bit rnd, output bit ok);
    ok = 0;
    for (int n = 0; n < 20000; n++) begin
      if (!busy) begin ok = 1; break; end
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_pixels(input int cnt, output bit ok);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (got.size() >= cnt) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", idx); else passed++;
    total++; if (select !== 4'd0) $display("FAIL reset_select got %0d want 0", select); else passed++;
    total++; if ({pix_valid, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {pix_valid, busy, done}); else passed++;
    total++; if ({pix_x, pix_y} !== 16'h0000) $display("FAIL reset_pix got %h want 0000", {pix_x, pix_y}); else passed++;
    rst = 0;
  endtask

  task automatic test_line();
    bit ok, consec;
    int d;
    clear_table(); t_dig = 3;
    set_seg(0, 0, 0, 3, 0, 1);
    pix_ready = 1;
    exp_q = {16'h0A14, 16'h0B14, 16'h0C14, 16'h0D14};
    start_digit(3, 10, 20);
    wait_idle(0, ok);
    total++; if (!ok) $display("FAIL line_timeout busy still %b", busy); else passed++;
    d = first_diff();
    total++; if (d >= 0) $display("FAIL line_pixels at %0d got size %0d want size %0d", d, got.size(), exp_q.size()); else passed++;
    consec = got.size() == 4;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) consec = 0;
    total++; if (!consec) $display("FAIL line_consecutive got %0d pixels not back-to-back want 4 consecutive", got.size()); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL line_done got %0d pulses want 1", done_cnt); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL line_after got busy/done %b want 00", {busy, done}); else passed++;
  endtask

  task automatic test_diag();
    bit ok;
    int d;
    clear_table(); t_dig = 1;
    set_seg(0, 0, 0, 2, 4, 1);
    exp_q = {16'h0000, 16'h0101, 16'h0102, 16'h0203, 16'h0204};
    start_digit(1, 0, 0);
    wait_idle(1, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL diag_fwd ok %b diff at %0d got size %0d want 5", ok, d, got.size()); else passed++;
    set_seg(0, 2, 4, 0, 0, 1);
    exp_q = {16'h0204, 16'h0103, 16'h0102, 16'h0001, 16'h0000};
    start_digit(1, 0, 0);
    wait_idle(1, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL diag_rev ok %b diff at %0d got size %0d want 5", ok, d, got.size()); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int d, n0;
    logic [15:0] hold;
    clear_table(); t_dig = 4;
    set_seg(0, 0, 0, 10, 0, 1);
    pix_ready = 1;
    model(5, 7);
    start_digit(4, 5, 7);
    wait_pixels(3, ok);
    total++; if (!ok) $display("FAIL bp_reach got %0d pixels want 3", got.size()); else passed++;
    pix_ready = 0;
    hold = {pix_x, pix_y};
    n0 = got.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (pix_valid !== 1'b1 || {pix_x, pix_y} !== hold)
        $display("FAIL bp_hold cycle %0d got valid %b pix %h want valid 1 pix %h", i, pix_valid, {pix_x, pix_y}, hold);
      else passed++;
    end
    total++; if (got.size() != n0) $display("FAIL bp_noaccept got %0d pixels want %0d", got.size(), n0); else passed++;
    @(posedge clk); #1;
    pix_ready = 1;
    wait_idle(0, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL bp_stream ok %b diff at %0d got size %0d want %0d", ok, d, got.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_skip();
    bit ok;
    int d;
    clear_table(); t_dig = 7;
    set_seg(0, 0, 0, 0, 1, 1);
    set_seg(1, 5, 5, 9, 9, 0);
    set_seg(2, 7, 7, 7, 7, 1);
    exp_q = {16'h0000, 16'h0001, 16'h0707};
    start_digit(7, 0, 0);
    wait_idle(1, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL skip_pixels ok %b diff at %0d got size %0d want 3", ok, d, got.size()); else passed++;
    total++; if (max_idx !== 5'd3) $display("FAIL skip_idx got %0d want 3", max_idx); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL skip_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_bad_select();
    bit ok;
    int d;
    clear_table(); t_dig = 3;
    set_seg(0, 0, 0, 3, 0, 1);
    pix_ready = 1;
    start_digit(12, 0, 0);
    wait_idle(0, ok);
    total++; if (!ok || got.size() != 0) $display("FAIL badsel_pixels ok %b got %0d want 0", ok, got.size()); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL badsel_done got %0d want 1", done_cnt); else passed++;
    model(1, 2);
    start_digit(3, 1, 2);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      start = busy; digit = 3; org_x = 100; org_y = 100;
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    start = 0;
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL busy_start ok %b diff at %0d got size %0d want %0d", ok, d, got.size(), exp_q.size()); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done_cnt != 1) $display("FAIL done_start got busy %b done %0d want 0 1", busy, done_cnt); else passed++;
    clear_table(); t_dig = 5;
    set_seg(0, 10, 10, 10, 10, 1);
    exp_q = {16'h0404};
    start_digit(5, 250, 250);
    wait_idle(0, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL wrap got size %0d first %h want 1 pixel 0404", got.size(), got.size() ? got[0] : 16'hxxxx); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d, n0;
    clear_table(); t_dig = 2;
    set_seg(0, 0, 0, 20, 5, 1);
    pix_ready = 1;
    start_digit(2, 3, 3);
    wait_pixels(2, ok);
    rst = 1;
    #1;
    total++; if ({pix_valid, busy} !== 2'b00 || idx !== 5'd0 || !ok) $display("FAIL rst_mid got valid %b busy %b idx %0d want 0 0 0", pix_valid, busy, idx); else passed++;
    n0 = got.size();
    repeat (3) @(posedge clk);
    #1;
    total++; if (got.size() != n0) $display("FAIL rst_quiet got %0d pixels want %0d", got.size(), n0); else passed++;
    rst = 0;
    model(3, 3);
    start_digit(2, 3, 3);
    wait_idle(1, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL rst_redraw ok %b diff at %0d got size %0d want %0d", ok, d, got.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_full_table();
    bit ok;
    int d;
    clear_table(); t_dig = 9;
    for (int i = 0; i < 32; i++) begin
      set_seg(i, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (t_sx[i] == 0 && t_sy[i] == 0 && t_ex[i] == 0 && t_ey[i] == 0) t_pen[i] = 1;
    end
    model(40, 60);
    start_digit(9, 40, 60);
    wait_idle(1, ok);
    d = first_diff();
    total++; if (!ok || d >= 0) $display("FAIL full_pixels ok %b diff at %0d got size %0d want %0d", ok, d, got.size(), exp_q.size()); else passed++;
    total++; if (max_idx !== 5'd31 || done_cnt != 1) $display("FAIL full_idx got idx %0d done %0d want 31 1", max_idx, done_cnt); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int d, n;
    logic [7:0] ox, oy;
    for (int it = 0; it < 15; it++) begin
      clear_table();
      t_dig = 4'($urandom_range(0, 9));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 7) == 0)
          set_seg(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        else
          set_seg(i, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)), $urandom_range(0, 3) != 0);
      ox = 8'($urandom); oy = 8'($urandom);
      model(ox, oy);
      start_digit(t_dig, ox, oy);
      wait_idle(1, ok);
      d = first_diff();
      total++;
      if (!ok || d >= 0 || done_cnt != 1)
        $display("FAIL random_%0d ok %b diff at %0d got size %0d want %0d done %0d want 1", it, ok, d, got.size(), exp_q.size(), done_cnt);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_diag();
    test_backpressure();
    test_skip();
    test_bad_select();
    test_reset_mid();
    test_full_table();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
